// File: rtl/painterengine_gpu_reader_arbiter.sv
// painterengine_gpu_reader_arbiter
// Shares one GPU DMA reader between PARAM_MASTERS requesters with
// round-robin arbitration at whole-transaction granularity.
// Optional ACTIVE-state stall watchdog: define READER_ARB_WATCHDOG_EN.
module painterengine_gpu_reader_arbiter #(
    parameter int PARAM_MASTERS = 2,
    parameter int PARAM_TIMEOUT = 4096
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_resetn,
    input  logic [32*PARAM_MASTERS-1:0] i_wire_req_address,
    input  logic [32*PARAM_MASTERS-1:0] i_wire_req_length,
    input  logic [PARAM_MASTERS-1:0]    i_wire_req_resetn,
    output logic [PARAM_MASTERS-1:0]    o_wire_req_done,
    output logic [PARAM_MASTERS-1:0]    o_wire_req_error,
    output logic [31:0]                 o_wire_req_data,
    output logic [PARAM_MASTERS-1:0]    o_wire_req_data_valid,
    input  logic [PARAM_MASTERS-1:0]    i_wire_req_data_next,
    output logic [31:0]                 o_wire_reader_address,
    output logic [31:0]                 o_wire_reader_length,
    output logic                        o_wire_reader_resetn,
    input  logic                        i_wire_reader_done,
    input  logic                        i_wire_reader_error,
    input  logic [31:0]                 i_wire_reader_data,
    input  logic                        i_wire_reader_data_valid,
    output logic                        o_wire_reader_data_next,
    output logic [PARAM_MASTERS-1:0]    o_wire_grant,
    output logic                        o_wire_busy
);

    localparam int IDX_W = $clog2(PARAM_MASTERS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [31:0]              r_reader_address, w_reader_address_next;
    logic [31:0]              r_reader_length,  w_reader_length_next;
    logic                     r_reader_resetn,  w_reader_resetn_next;
    logic [PARAM_MASTERS-1:0] r_done,  w_done_next;
    logic [PARAM_MASTERS-1:0] r_error, w_error_next;
    logic [PARAM_MASTERS-1:0] r_grant, w_grant_next;
    logic [IDX_W-1:0]         r_gidx,  w_gidx_next;
    logic [IDX_W-1:0]         r_last,  w_last_next;
    logic                     r_busy;

    logic                     w_found;
    logic [IDX_W-1:0]         w_sel;
    logic [IDX_W-1:0]         w_cand;
    logic [31:0]              w_sel_address;
    logic [31:0]              w_sel_length;
    logic                     w_g_req;
    logic                     w_active_ok;
    logic                     w_wd_expire;

    // Round-robin pick: first requester at or after last_grant+1
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= PARAM_MASTERS; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % PARAM_MASTERS);
            if (!w_found && i_wire_req_resetn[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Mux the selected master's address/length for latching
    always_comb begin
        w_sel_address = 32'd0;
        w_sel_length  = 32'd0;
        for (int k = 0; k < PARAM_MASTERS; k++) begin
            if (w_sel == IDX_W'(k)) begin
                w_sel_address = i_wire_req_address[32*k +: 32];
                w_sel_length  = i_wire_req_length[32*k +: 32];
            end else begin
                w_sel_address = w_sel_address;
            end
        end
    end

    assign w_g_req     = i_wire_req_resetn[r_gidx];
    assign w_active_ok = (r_state == ST_ACTIVE) && w_g_req;

`ifdef READER_ARB_WATCHDOG_EN
    logic [31:0] r_wd_cnt;

    assign w_wd_expire = (r_state == ST_ACTIVE) && !i_wire_reader_data_valid &&
                         !i_wire_reader_done && (r_wd_cnt == 32'(PARAM_TIMEOUT - 1));

    // Stall counter: counts idle ACTIVE cycles, cleared by any reader activity
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_wd_cnt <= 32'd0;
        end else if ((r_state == ST_ACTIVE) && !i_wire_reader_data_valid && !i_wire_reader_done) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end else begin
            r_wd_cnt <= 32'd0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(32'(PARAM_TIMEOUT));
    assign w_wd_expire      = 1'b0;
`endif

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        w_state_next          = r_state;
        w_reader_address_next = r_reader_address;
        w_reader_length_next  = r_reader_length;
        w_reader_resetn_next  = r_reader_resetn;
        w_done_next           = r_done;
        w_error_next          = r_error;
        w_grant_next          = r_grant;
        w_gidx_next           = r_gidx;
        w_last_next           = r_last;
        case (r_state)
            ST_IDLE: begin
                w_reader_resetn_next = 1'b0;
                if (w_found) begin
                    w_reader_address_next = w_sel_address;
                    w_reader_length_next  = w_sel_length;
                    w_grant_next          = PARAM_MASTERS'(1) << w_sel;
                    w_gidx_next           = w_sel;
                    w_state_next          = ST_GRANT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Reader is held closed for this one cycle so it starts clean
                if (!w_g_req) begin
                    w_reader_resetn_next = 1'b0;
                    w_state_next         = ST_RELEASE;
                end else if (r_reader_length == 32'd0) begin
                    w_reader_resetn_next = 1'b0;
                    w_done_next          = r_done | r_grant;
                    w_state_next         = ST_HOLD;
                end else begin
                    w_reader_resetn_next = 1'b1;
                    w_state_next         = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!w_g_req) begin
                    w_reader_resetn_next = 1'b0;
                    w_state_next         = ST_RELEASE;
                end else if (i_wire_reader_error || w_wd_expire) begin
                    // Error dominates a coincident done
                    w_error_next         = r_error | r_grant;
                    w_reader_resetn_next = 1'b0;
                    w_state_next         = ST_HOLD;
                end else if (i_wire_reader_done) begin
                    w_done_next  = r_done | r_grant;
                    w_state_next = ST_HOLD;
                end else begin
                    w_reader_resetn_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_g_req) begin
                    w_done_next          = '0;
                    w_error_next         = '0;
                    w_reader_resetn_next = 1'b0;
                    w_state_next         = ST_RELEASE;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                w_reader_resetn_next = 1'b0;
                w_last_next          = r_gidx;
                w_grant_next         = '0;
                w_state_next         = ST_IDLE;
            end
            default: begin
                w_reader_resetn_next = 1'b0;
                w_grant_next         = '0;
                w_done_next          = '0;
                w_error_next         = '0;
                w_state_next         = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_state          <= ST_IDLE;
            r_reader_address <= 32'd0;
            r_reader_length  <= 32'd0;
            r_reader_resetn  <= 1'b0;
            r_done           <= '0;
            r_error          <= '0;
            r_grant          <= '0;
            r_gidx           <= '0;
            r_last           <= IDX_W'(PARAM_MASTERS - 1);
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_reader_address <= w_reader_address_next;
            r_reader_length  <= w_reader_length_next;
            r_reader_resetn  <= w_reader_resetn_next;
            r_done           <= w_done_next;
            r_error          <= w_error_next;
            r_grant          <= w_grant_next;
            r_gidx           <= w_gidx_next;
            r_last           <= w_last_next;
            r_busy           <= (w_state_next != ST_IDLE);
        end
    end

    // Route reader valid to the granted master only, dropping it once aborted
    always_comb begin
        if (w_active_ok && i_wire_reader_data_valid) begin
            o_wire_req_data_valid = r_grant;
        end else begin
            o_wire_req_data_valid = '0;
        end
    end

    assign o_wire_reader_data_next = w_active_ok ? i_wire_req_data_next[r_gidx] : 1'b0;
    assign o_wire_req_data         = i_wire_reader_data;
    assign o_wire_req_done         = r_done;
    assign o_wire_req_error        = r_error;
    assign o_wire_reader_address   = r_reader_address;
    assign o_wire_reader_length    = r_reader_length;
    assign o_wire_reader_resetn    = r_reader_resetn;
    assign o_wire_grant            = r_grant;
    assign o_wire_busy             = r_busy;

endmodule
